sm_led_status_ctrl: RTL

- Parametrised RGB status-LED controller for the soil-monitoring bot. It latches each colour-sensor detection into the next free LED slot, giving a visible history of detections along the run.
- Slots are cleared when the bot enters a configured clear node.
- The most recent slot can optionally blink.
- Sits between the colour-detection logic / path-node tracker and the board's RGB LED pins.

---
 rtl/sm_led_status_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sm_led_status_ctrl.sv
// sm_led_status_ctrl
// RGB status-LED history controller. Each rising edge on a colour-detection
// input is latched into the next free LED slot. Entering a clear node empties
// the history. The most recently written slot can optionally blink.
// All outputs are registered, so a detection shows up one edge after it is seen.

module sm_led_status_ctrl #(
    parameter int NUM_LEDS   = 3,
    parameter int NODE_W     = 6,
    parameter int CLR_NODE_A = 11,
    parameter int CLR_NODE_B = 22,
    parameter int BLINK_HALF = 25000000,
    parameter int SATURATE   = 1
) (
    input  logic                              clk_50,
    input  logic                              reset,
    input  logic                              red,
    input  logic                              green,
    input  logic                              blue,
    input  logic [NODE_W-1:0]                 node,
    input  logic                              blink_en,
    output logic [NUM_LEDS-1:0]               led_red,
    output logic [NUM_LEDS-1:0]               led_green,
    output logic [NUM_LEDS-1:0]               led_blue,
    output logic [$clog2(NUM_LEDS+1)-1:0]     count,
    output logic                              full
);

    localparam int CNT_W = $clog2(NUM_LEDS + 1);
    localparam int PTR_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int BLK_W = $clog2(BLINK_HALF);

    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NUM_LEDS);
    localparam logic [BLK_W-1:0]  BLK_TOP  = BLK_W'(BLINK_HALF - 1);
    localparam logic [NODE_W-1:0] CLR_A    = NODE_W'(CLR_NODE_A);
    localparam logic [NODE_W-1:0] CLR_B    = NODE_W'(CLR_NODE_B);

    // History of inputs, used for edge / node-entry detection
    logic               r_red_prev;
    logic               r_green_prev;
    logic               r_blue_prev;
    logic [NODE_W-1:0]  r_node_prev;

    // Stored slot contents (never touched by blink gating)
    logic [NUM_LEDS-1:0] r_slot_red;
    logic [NUM_LEDS-1:0] r_slot_green;
    logic [NUM_LEDS-1:0] r_slot_blue;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_last;
    logic [CNT_W-1:0]    r_count;

    // Blink timebase; r_phase = 1 means the newest slot is lit
    logic [BLK_W-1:0]    r_blink_cnt;
    logic                r_phase;

    // Registered outputs
    logic [NUM_LEDS-1:0] r_led_red;
    logic [NUM_LEDS-1:0] r_led_green;
    logic [NUM_LEDS-1:0] r_led_blue;
    logic                r_full;

    // Edge detection and one-hot colour selection (green > red > blue)
    logic w_rise_r;
    logic w_rise_g;
    logic w_rise_b;
    logic w_event;
    logic w_col_r;
    logic w_col_g;
    logic w_col_b;
    logic w_clear;
    logic w_accept;
    logic w_restart;

    assign w_rise_r = red   & ~r_red_prev;
    assign w_rise_g = green & ~r_green_prev;
    assign w_rise_b = blue  & ~r_blue_prev;
    assign w_event  = w_rise_r | w_rise_g | w_rise_b;
    assign w_col_g  = w_rise_g;
    assign w_col_r  = ~w_rise_g & w_rise_r;
    assign w_col_b  = ~w_rise_g & ~w_rise_r & w_rise_b;

    // A clear only fires on entry into a clear node, not while dwelling there
    assign w_clear = ((node == CLR_A) || (node == CLR_B)) && (node != r_node_prev);

    // State after a possible clear; a same-cycle event is then written on top
    logic [NUM_LEDS-1:0] w_red_base;
    logic [NUM_LEDS-1:0] w_green_base;
    logic [NUM_LEDS-1:0] w_blue_base;
    logic [PTR_W-1:0]    w_ptr_base;
    logic [CNT_W-1:0]    w_count_base;

    assign w_red_base   = w_clear ? '0 : r_slot_red;
    assign w_green_base = w_clear ? '0 : r_slot_green;
    assign w_blue_base  = w_clear ? '0 : r_slot_blue;
    assign w_ptr_base   = w_clear ? '0 : r_ptr;
    assign w_count_base = w_clear ? '0 : r_count;

    // In saturating mode a full history swallows further events entirely
    assign w_accept  = w_event && !((SATURATE != 0) && (w_count_base == FULL_CNT));
    assign w_restart = w_clear | w_accept;

    logic [NUM_LEDS-1:0] w_red_nx;
    logic [NUM_LEDS-1:0] w_green_nx;
    logic [NUM_LEDS-1:0] w_blue_nx;
    logic [PTR_W-1:0]    w_ptr_nx;
    logic [PTR_W-1:0]    w_last_nx;
    logic [CNT_W-1:0]    w_count_nx;
    logic [BLK_W-1:0]    w_blink_cnt_nx;
    logic                w_phase_nx;
    logic [NUM_LEDS-1:0] w_mask;
    logic                w_blank;

    // Slot write: the accepted event lands in the slot at the write pointer
    always_comb begin
        w_red_nx   = w_red_base;
        w_green_nx = w_green_base;
        w_blue_nx  = w_blue_base;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (w_accept && (w_ptr_base == PTR_W'(i))) begin
                w_red_nx[i]   = w_col_r;
                w_green_nx[i] = w_col_g;
                w_blue_nx[i]  = w_col_b;
            end else begin
                w_red_nx[i]   = w_red_base[i];
                w_green_nx[i] = w_green_base[i];
                w_blue_nx[i]  = w_blue_base[i];
            end
        end
    end

    // Pointer, newest-slot index and fill count bookkeeping
    always_comb begin
        w_ptr_nx   = w_ptr_base;
        w_last_nx  = r_last;
        w_count_nx = w_count_base;
        if (w_accept) begin
            w_ptr_nx  = (w_ptr_base == LAST_IDX) ? '0 : (w_ptr_base + PTR_W'(1));
            w_last_nx = w_ptr_base;
            if (w_count_base != FULL_CNT) begin
                w_count_nx = w_count_base + CNT_W'(1);
            end else begin
                w_count_nx = w_count_base;
            end
        end else begin
            w_ptr_nx   = w_ptr_base;
            w_last_nx  = r_last;
            w_count_nx = w_count_base;
        end
    end

    // Blink timebase: restarts lit on every write or clear, otherwise free-runs
    always_comb begin
        w_blink_cnt_nx = r_blink_cnt;
        w_phase_nx     = r_phase;
        if (w_restart) begin
            w_blink_cnt_nx = '0;
            w_phase_nx     = 1'b1;
        end else if (r_blink_cnt == BLK_TOP) begin
            w_blink_cnt_nx = '0;
            w_phase_nx     = ~r_phase;
        end else begin
            w_blink_cnt_nx = r_blink_cnt + BLK_W'(1);
            w_phase_nx     = r_phase;
        end
    end

    // Output gating: only the newest slot is blanked during the off phase
    always_comb begin
        w_mask  = '0;
        w_blank = blink_en && (w_count_nx != '0) && !w_phase_nx;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (w_blank && (w_last_nx == PTR_W'(i))) begin
                w_mask[i] = 1'b1;
            end else begin
                w_mask[i] = 1'b0;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_red_prev   <= 1'b0;
            r_green_prev <= 1'b0;
            r_blue_prev  <= 1'b0;
            r_node_prev  <= '0;
            r_slot_red   <= '0;
            r_slot_green <= '0;
            r_slot_blue  <= '0;
            r_ptr        <= '0;
            r_last       <= '0;
            r_count      <= '0;
            r_blink_cnt  <= '0;
            r_phase      <= 1'b1;
            r_led_red    <= '0;
            r_led_green  <= '0;
            r_led_blue   <= '0;
            r_full       <= 1'b0;
        end else begin
            r_red_prev   <= red;
            r_green_prev <= green;
            r_blue_prev  <= blue;
            r_node_prev  <= node;
            r_slot_red   <= w_red_nx;
            r_slot_green <= w_green_nx;
            r_slot_blue  <= w_blue_nx;
            r_ptr        <= w_ptr_nx;
            r_last       <= w_last_nx;
            r_count      <= w_count_nx;
            r_blink_cnt  <= w_blink_cnt_nx;
            r_phase      <= w_phase_nx;
            r_led_red    <= w_red_nx   & ~w_mask;
            r_led_green  <= w_green_nx & ~w_mask;
            r_led_blue   <= w_blue_nx  & ~w_mask;
            r_full       <= (w_count_nx == FULL_CNT);
        end
    end

    assign led_red   = r_led_red;
    assign led_green = r_led_green;
    assign led_blue  = r_led_blue;
    assign count     = r_count;
    assign full      = r_full;

endmodule
